sram_march_bist: RTL

- Built-in self-test controller that acts as the access initiator for the team's 8T SRAM macro port (cs/re/we/addr/din/dout).
- Runs a March C- sequence over every address, compares the read data, and reports pass/fail, the first failing address and data, and a failure count.
- Sits between the SoC test-control register block and the SRAM instance, muxed ahead of functional traffic at the top level.

---
 rtl/sram_bist_pkg.sv | 33 +++
 rtl/sram_bist_addr_gen.sv | 40 ++++
 rtl/sram_march_bist.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
package sram_bist_pkg;

    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;
    typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    // Bit i of each table belongs to element Ei.
    localparam logic [5:0] ELEM_DOWN = 6'b011000;
    localparam logic [5:0] ELEM_RPOL = 6'b010100;
    localparam logic [5:0] ELEM_WPOL = 6'b001010;

    function automatic logic elem_down(input elem_e e);
        return ELEM_DOWN[e];
    endfunction

    function automatic logic rd_pol(input elem_e e);
        return ELEM_RPOL[e];
    endfunction

    function automatic logic wr_pol(input elem_e e);
        return ELEM_WPOL[e];
    endfunction

    function automatic logic elem_is_pair(input elem_e e);
        return (e != E0) && (e != E5);
    endfunction

    function automatic op_e first_op(input elem_e e);
        return (e == E0) ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter; direction is latched when an element starts.
module sram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic                  dir_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  first_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            dir_q  <= 1'b0;
        end else if (clr_i) begin
            addr_q <= '0;
            dir_q  <= 1'b0;
        end else if (load_i) begin
            dir_q  <= dir_i;
            addr_q <= dir_i ? ADDR_MAX : '0;
        end else if (step_i) begin
            addr_q <= dir_q ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    assign addr_o  = addr_q;
    assign first_o = (addr_q == (dir_q ? ADDR_MAX : '0));
    assign last_o  = (addr_q == (dir_q ? '0 : ADDR_MAX));

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller: drives the SRAM port one op per cycle and checks reads one cycle later.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] BG         = {DATA_WIDTH{1'b0}},
    parameter int                    CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [CNT_WIDTH-1:0]  fail_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic [DATA_WIDTH-1:0] fail_exp_o,
    output logic                  mem_cs_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i
);

    state_e                state_q;
    elem_e                 elem_q, elem_d;
    op_e                   op_q, op_d;
    logic                  busy_q, done_q, pass_q;
    logic                  mem_cs_q, mem_re_q, mem_we_q;
    logic [DATA_WIDTH-1:0] mem_din_q;
    logic                  cmp_vld_q;
    logic [DATA_WIDTH-1:0] cmp_exp_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;
    logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_exp_q;
    logic                  elem_start_q;

    logic                  load_run, step_run, run_end, mism;
    logic                  ag_load, ag_step, ag_clr, ag_dir, ag_first, ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;

    // Sequencing from the op currently on the bus to the next one.
    always_comb begin
        elem_d   = elem_q;
        op_d     = op_q;
        load_run = 1'b0;
        step_run = 1'b0;
        run_end  = 1'b0;
        if (op_q == OP_RD && elem_is_pair(elem_q)) begin
            op_d = OP_WR;
        end else if (!ag_last) begin
            step_run = 1'b1;
            if (elem_is_pair(elem_q)) op_d = OP_RD;
        end else if (elem_q == E5) begin
            run_end = 1'b1;
        end else begin
            elem_d   = elem_e'(elem_q + 3'd1);
            op_d     = first_op(elem_d);
            load_run = 1'b1;
        end
    end

    assign ag_load = (state_q == IDLE && start_i) || (state_q == RUN && load_run);
    assign ag_dir  = (state_q == RUN) ? elem_down(elem_d) : 1'b0;
    assign ag_step = (state_q == RUN) && step_run;
    assign ag_clr  = (state_q == RUN) && run_end;

    sram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (ag_clr),
        .load_i  (ag_load),
        .dir_i   (ag_dir),
        .step_i  (ag_step),
        .addr_o  (ag_addr),
        .first_o (ag_first),
        .last_o  (ag_last)
    );

    // X/Z on the read bus must count as a mismatch, hence the case inequality.
    assign mism       = cmp_vld_q && (mem_dout_i !== cmp_exp_q);
    assign fail_cnt_d = !mism ? fail_cnt_q :
                        (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            elem_q       <= E0;
            op_q         <= OP_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            mem_cs_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_din_q    <= '0;
            cmp_vld_q    <= 1'b0;
            cmp_exp_q    <= '0;
            cmp_addr_q   <= '0;
            fail_cnt_q   <= '0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            fail_exp_q   <= '0;
            elem_start_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            elem_start_q <= ag_load;
            cmp_vld_q    <= mem_re_q;
            cmp_exp_q    <= BG ^ {DATA_WIDTH{rd_pol(elem_q)}};
            cmp_addr_q   <= ag_addr;
            fail_cnt_q   <= fail_cnt_d;
            if (mism && fail_cnt_q == '0) begin
                fail_addr_q <= cmp_addr_q;
                fail_data_q <= mem_dout_i;
                fail_exp_q  <= cmp_exp_q;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        fail_cnt_q  <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        fail_exp_q  <= '0;
                        elem_q      <= E0;
                        op_q        <= OP_WR;
                        mem_cs_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_din_q   <= BG ^ {DATA_WIDTH{wr_pol(E0)}};
                    end
                end
                RUN: begin
                    if (run_end) begin
                        state_q   <= DRAIN;
                        op_q      <= OP_IDLE;
                        mem_cs_q  <= 1'b0;
                        mem_re_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_din_q <= '0;
                    end else begin
                        elem_q    <= elem_d;
                        op_q      <= op_d;
                        mem_cs_q  <= 1'b1;
                        mem_re_q  <= (op_d == OP_RD);
                        mem_we_q  <= (op_d == OP_WR);
                        mem_din_q <= (op_d == OP_WR) ? (BG ^ {DATA_WIDTH{wr_pol(elem_d)}}) : '0;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (fail_cnt_d == '0);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_elem_first: assert property (@(posedge clk) disable iff (!rst_n) elem_start_q |-> ag_first);

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign fail_count_o = fail_cnt_q;
    assign fail_addr_o  = fail_addr_q;
    assign fail_data_o  = fail_data_q;
    assign fail_exp_o   = fail_exp_q;
    assign mem_cs_o     = mem_cs_q;
    assign mem_re_o     = mem_re_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = ag_addr;
    assign mem_din_o    = mem_din_q;

endmodule
